zoom_view_ctrl: RTL and testbench

Upstream control stage for the QVGA upscale address decoder. Synchronizes and debounces the four push-buttons and the centre/control switches, then resolves them into one zoom view. The view is committed only on a frame boundary, so the image never tears mid-frame. Outputs a registered view code, window origin and zoom enable, which the address decoder consumes directly.

---
 rtl/zoom_view_pkg.sv | 35 +++
 rtl/btn_debounce.sv | 44 ++++
 rtl/zoom_view_ctrl.sv | 116 +++++++++++
 tb/tb_zoom_view_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zoom_view_pkg.sv
// zoom_view_pkg
// Shared types and constants for the zoom view control stage.
//   view_e      : committed/pending view code (3 bits)
//   X_HALF, Y_HALF, X_CTR, Y_CTR : window origins in 640x480 space
//   view_origin : maps a view code to its {x_start, y_start} origin
package zoom_view_pkg;

   typedef enum logic [2:0] {
      V_FULL   = 3'd0,
      V_TL     = 3'd1,
      V_TR     = 3'd2,
      V_BR     = 3'd3,
      V_BL     = 3'd4,
      V_CENTER = 3'd5
   } view_e;

   localparam logic [9:0] X_HALF = 10'd320;
   localparam logic [9:0] Y_HALF = 10'd240;
   localparam logic [9:0] X_CTR  = 10'd160;
   localparam logic [9:0] Y_CTR  = 10'd120;

   // Returns {x_start[9:0], y_start[9:0]}.
   function automatic logic [19:0] view_origin(input view_e v);
      logic [19:0] o;
      case (v)
         V_TR:     o = {X_HALF, 10'd0};
         V_BR:     o = {X_HALF, Y_HALF};
         V_BL:     o = {10'd0,  Y_HALF};
         V_CENTER: o = {X_CTR,  Y_CTR};
         default:  o = 20'd0;   // FULL and TL share the origin
      endcase
      return o;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// 2-FF synchronizer followed by a stability counter for one raw button.
// The debounced level flips only after the synchronized input has differed
// from it for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous, active-high
//   raw    in  asynchronous, bouncing button input
//   level  out debounced level (registered)
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level
);

   logic             s1, s2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         if (s2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            // this cycle is the DEBOUNCE_CYCLES-th consecutive mismatch
            level <= ~level;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/zoom_view_ctrl.sv
// zoom_view_ctrl
// Conditions the four push-buttons and two slide switches, resolves them
// into a pending zoom view and commits it on frame_start so the image never
// changes mid-frame.
// Build option: define ZOOM_LATCH_EN for latched mode (button edges set or
// toggle the view); default is momentary mode (view follows held buttons).
// Ports:
//   clk, reset               rising-edge clock, synchronous active-high reset
//   btnU, btnL, btnR, btnD   raw push-buttons
//   center_SW                raw switch, selects centre view when idle
//   control_SW               raw switch, 0 forces the full view
//   frame_start              one-cycle pulse at start of vertical blank
//   zoom_en                  committed view is not FULL
//   x_start, y_start         committed window origin
//   view                     committed view code
module zoom_view_ctrl
   import zoom_view_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btnU,
   input  logic       btnL,
   input  logic       btnR,
   input  logic       btnD,
   input  logic       center_SW,
   input  logic       control_SW,
   input  logic       frame_start,
   output logic       zoom_en,
   output logic [9:0] x_start,
   output logic [9:0] y_start,
   output logic [2:0] view
);

   // bit order is the priority order: L, U, R, D
   logic [3:0] btn_raw, btn_lvl, btn_sel;
   logic [1:0] sw_s1, sw_s2;   // {control, center}
   view_e      pending, btn_view, base, pend_nxt;

   assign btn_raw = {btnD, btnR, btnU, btnL};

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_db [3:0] (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_raw),
      .level(btn_lvl)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         sw_s1 <= '0;
         sw_s2 <= '0;
      end else begin
         sw_s1 <= {control_SW, center_SW};
         sw_s2 <= sw_s1;
      end
   end

`ifdef ZOOM_LATCH_EN
   logic [3:0] btn_q;

   always_ff @(posedge clk) begin
      if (reset) btn_q <= '0;
      else       btn_q <= btn_lvl;
   end

   assign btn_sel = btn_lvl & ~btn_q;   // one-cycle rising edges
`else
   assign btn_sel = btn_lvl;
`endif

   always_comb begin
      btn_view = V_FULL;
      if      (btn_sel[0]) btn_view = V_TL;
      else if (btn_sel[1]) btn_view = V_TR;
      else if (btn_sel[2]) btn_view = V_BR;
      else if (btn_sel[3]) btn_view = V_BL;
   end

   always_comb begin
`ifdef ZOOM_LATCH_EN
      base = pending;
      if (|btn_sel) base = (btn_view == pending) ? V_FULL : btn_view;
`else
      base = btn_view;
`endif
      if (!sw_s2[1])                       pend_nxt = V_FULL;
      else if (base == V_FULL && sw_s2[0]) pend_nxt = V_CENTER;
      else                                 pend_nxt = base;
   end

   // commit samples the pending value held before this edge, so a button
   // edge coinciding with frame_start lands in the next frame
   always_ff @(posedge clk) begin
      if (reset) begin
         pending <= V_FULL;
         view    <= V_FULL;
         zoom_en <= 1'b0;
         x_start <= '0;
         y_start <= '0;
      end else begin
         pending <= pend_nxt;
         if (frame_start) begin
            view               <= pending;
            {x_start, y_start} <= view_origin(pending);
            zoom_en            <= (pending != V_FULL);
         end
      end
   end

endmodule

// File: tb/tb_zoom_view_ctrl.sv
module tb_zoom_view_ctrl;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       reset, btnU, btnL, btnR, btnD, center_SW, control_SW, frame_start;
   logic       zoom_en;
   logic [9:0] x_start, y_start;
   logic [2:0] view;

   int n_checks = 0;
   int n_fail   = 0;

   zoom_view_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
      .clk        (clk),
      .reset      (reset),
      .btnU       (btnU),
      .btnL       (btnL),
      .btnR       (btnR),
      .btnD       (btnD),
      .center_SW  (center_SW),
      .control_SW (control_SW),
      .frame_start(frame_start),
      .zoom_en    (zoom_en),
      .x_start    (x_start),
      .y_start    (y_start),
      .view       (view)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // buttons indexed in priority order: 0=L 1=U 2=R 3=D
   bit       m_s1[6], m_s2[6];   // 0..3 buttons, 4 center, 5 control
   bit       m_db[4], m_dbq[4];
   bit       m_hist[4][$];       // recent synchronized samples
   int       m_pend, m_view;

   function automatic int org_x(input int v);
      return (v == 2 || v == 3) ? 320 : (v == 5) ? 160 : 0;
   endfunction
   function automatic int org_y(input int v);
      return (v == 3 || v == 4) ? 240 : (v == 5) ? 120 : 0;
   endfunction

   function automatic void model_edge();
      bit raw[6];
      bit sel[4];
      bit any;
      int bv, base, np;
      bit all_diff;
      if (reset) begin
         for (int i = 0; i < 6; i++) begin m_s1[i] = 0; m_s2[i] = 0; end
         for (int i = 0; i < 4; i++) begin m_db[i] = 0; m_dbq[i] = 0; m_hist[i].delete(); end
         m_pend = 0; m_view = 0;
         return;
      end
      raw = '{btnL, btnU, btnR, btnD, center_SW, control_SW};
      any = 0;
      for (int i = 0; i < 4; i++) begin
`ifdef ZOOM_LATCH_EN
         sel[i] = m_db[i] && !m_dbq[i];
`else
         sel[i] = m_db[i];
`endif
         any |= sel[i];
      end
      bv = 0;
      for (int i = 3; i >= 0; i--) if (sel[i]) bv = i + 1;   // lowest index wins
`ifdef ZOOM_LATCH_EN
      base = any ? ((bv == m_pend) ? 0 : bv) : m_pend;
`else
      base = bv;
`endif
      if (!m_s2[5])                  np = 0;
      else if (base == 0 && m_s2[4]) np = 5;
      else                           np = base;
      if (frame_start) m_view = m_pend;
      m_pend = np;
      for (int i = 0; i < 4; i++) begin
         m_dbq[i] = m_db[i];
         m_hist[i].push_back(m_s2[i]);
         if (m_hist[i].size() > D) void'(m_hist[i].pop_front());
         all_diff = (m_hist[i].size() == D);
         foreach (m_hist[i][k]) if (m_hist[i][k] == m_db[i]) all_diff = 0;
         if (all_diff) m_db[i] = !m_db[i];
      end
      for (int i = 0; i < 6; i++) begin m_s2[i] = m_s1[i]; m_s1[i] = raw[i]; end
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse_fs();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   task automatic idle_inputs();
      btnU = 0; btnL = 0; btnR = 0; btnD = 0; frame_start = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1; btnU = 1; btnL = 1; btnR = 1; btnD = 1;
      center_SW = 1; control_SW = 1; frame_start = 1;
      steps(3);
      n_checks++;
      if (view !== 3'd0 || zoom_en !== 1'b0 || x_start !== 10'd0 || y_start !== 10'd0) begin
         n_fail++;
         $display("FAIL reset: view=%0d zoom_en=%0d x=%0d y=%0d, want 0 0 0 0",
                  view, zoom_en, x_start, y_start);
      end
      idle_inputs(); center_SW = 0;
      step();
      reset = 0;
   endtask

   task automatic test_commit_timing();
      control_SW = 1;
      btnR = 1;
      for (int i = 0; i < 10; i++) begin
         step();
         n_checks++;
         if (view !== 3'd0 || zoom_en !== 1'b0) begin
            n_fail++;
            $display("FAIL commit_hold: cycle %0d view=%0d zoom_en=%0d, want 0 0", i, view, zoom_en);
         end
      end
      pulse_fs();
      n_checks++;
      if (view !== 3'd3 || x_start !== 10'd320 || y_start !== 10'd240 || zoom_en !== 1'b1) begin
         n_fail++;
         $display("FAIL commit: view=%0d x=%0d y=%0d zoom_en=%0d, want 3 320 240 1",
                  view, x_start, y_start, zoom_en);
      end
      btnR = 0;
      steps(10);
      n_checks++;
      if (view !== 3'd3) begin
         n_fail++;
         $display("FAIL commit_stable: view=%0d, want 3 without frame_start", view);
      end
   endtask

   task automatic test_bounce();
      for (int i = 0; i < 20; i++) begin
         if (i % 2 == 0) btnU = ~btnU;
         step();
      end
      btnU = 0;
      steps(2);
      pulse_fs();
      n_checks++;
      if (view !== 3'd0 || zoom_en !== 1'b0) begin
         n_fail++;
         $display("FAIL bounce: view=%0d zoom_en=%0d, want 0 0", view, zoom_en);
      end
   endtask

   task automatic test_priority();
      btnL = 1; btnD = 1;
      steps(8);
      pulse_fs();
      n_checks++;
      if (view !== 3'd1 || x_start !== 10'd0 || y_start !== 10'd0 || zoom_en !== 1'b1) begin
         n_fail++;
         $display("FAIL priority: view=%0d x=%0d y=%0d zoom_en=%0d, want 1 0 0 1",
                  view, x_start, y_start, zoom_en);
      end
      btnL = 0; btnD = 0;
      steps(8);
   endtask

   task automatic test_override();
      btnR = 1; control_SW = 0;
      steps(10);
      pulse_fs();
      n_checks++;
      if (view !== 3'd0 || zoom_en !== 1'b0) begin
         n_fail++;
         $display("FAIL override: view=%0d zoom_en=%0d, want 0 0", view, zoom_en);
      end
      btnR = 0;
      steps(8);
      control_SW = 1; center_SW = 1;
      steps(4);
      pulse_fs();
      n_checks++;
      if (view !== 3'd5 || x_start !== 10'd160 || y_start !== 10'd120 || zoom_en !== 1'b1) begin
         n_fail++;
         $display("FAIL center: view=%0d x=%0d y=%0d zoom_en=%0d, want 5 160 120 1",
                  view, x_start, y_start, zoom_en);
      end
      center_SW = 0;
      reset = 1; steps(2); reset = 0;
   endtask

`ifdef ZOOM_LATCH_EN
   task automatic test_latch();
      bit found;
      btnU = 1; steps(8); btnU = 0; steps(8);
      pulse_fs();
      n_checks++;
      if (view !== 3'd2) begin
         n_fail++;
         $display("FAIL latch_set: view=%0d, want 2", view);
      end
      btnU = 1; steps(8); btnU = 0; steps(8);
      pulse_fs();
      n_checks++;
      if (view !== 3'd0) begin
         n_fail++;
         $display("FAIL latch_toggle: view=%0d, want 0", view);
      end
      // line frame_start up with the edge cycle of a fresh btnU press
      btnU = 1; found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (m_db[1] && !m_dbq[1]) begin frame_start = 1; found = 1; end
         step();
         frame_start = 0;
      end
      n_checks++;
      if (!found || view !== 3'd0) begin
         n_fail++;
         $display("FAIL latch_same_cycle: found=%0d view=%0d, want 1 0", found, view);
      end
      btnU = 0; steps(8);
      pulse_fs();
      n_checks++;
      if (view !== 3'd2) begin
         n_fail++;
         $display("FAIL latch_next_frame: view=%0d, want 2", view);
      end
      reset = 1; steps(2); reset = 0;
   endtask
`endif

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 5) == 0) btnL = ~btnL;
         if ($urandom_range(0, 5) == 0) btnU = ~btnU;
         if ($urandom_range(0, 5) == 0) btnR = ~btnR;
         if ($urandom_range(0, 5) == 0) btnD = ~btnD;
         if ($urandom_range(0, 40) == 0) center_SW = ~center_SW;
         if ($urandom_range(0, 80) == 0) control_SW = ~control_SW;
         frame_start = ($urandom_range(0, 9) == 0);
         reset = ($urandom_range(0, 300) == 0);
         step();
         n_checks++;
         if (view !== 3'(m_view) || x_start !== 10'(org_x(m_view)) ||
             y_start !== 10'(org_y(m_view)) || zoom_en !== (m_view != 0)) begin
            n_fail++;
            $display("FAIL random: cycle %0d view=%0d x=%0d y=%0d zoom_en=%0d, want %0d %0d %0d %0d",
                     c, view, x_start, y_start, zoom_en,
                     m_view, org_x(m_view), org_y(m_view), (m_view != 0));
         end
      end
      reset = 0; frame_start = 0;
   endtask

   initial begin
      test_reset();
      test_commit_timing();
      test_bounce();
      test_priority();
      test_override();
`ifdef ZOOM_LATCH_EN
      test_latch();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
